// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Pointer and status controller that turns a synchronous-write
//                / asynchronous-read register file into a FIFO of
//                2**ADDR_WIDTH entries. Provides occupancy, full/empty,
//                programmable almost-full/almost-empty and sticky
//                overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Occupancy is one bit wider than the pointers so that depth itself fits.
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_AF_LEVEL = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   c_AE_LEVEL = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH+1)'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1'b1);

    logic [ADDR_WIDTH-1:0] r_w_ptr;
    logic [ADDR_WIDTH-1:0] r_r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Status flags decode from the registered count only, so they are glitch-free.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is legal when a pop frees the slot in the same
    // cycle; a pop from an empty FIFO is never legal, even with a push present.
    assign w_push_ok = wr & (~w_full | rd);
    assign w_pop_ok  = rd & ~w_empty;

    assign wr_en        = w_push_ok;
    assign w_addr       = r_w_ptr;
    assign r_addr       = r_r_ptr;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointer, occupancy and sticky error state; clr flushes with priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_w_ptr <= r_w_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_r_ptr <= r_r_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Self-checking bench for fifo_ctrl with a register-file model
//                and a queue-based FIFO reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int ADDR_WIDTH = 2;
    localparam int AF_LEVEL   = 3;
    localparam int AE_LEVEL   = 1;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                  clk;
    logic                  reset_n;
    logic                  clr;
    logic                  wr;
    logic                  rd;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    logic [7:0] w_data;
    logic [7:0] r_data;
    logic [7:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_unf;
    int         m_wcnt;
    int         m_rcnt;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= w_data;
    end
    assign r_data = mem[r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_wcnt = 0;
        m_rcnt = 0;
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
        chk("w_addr",       32'(w_addr),       32'(m_wcnt % DEPTH));
        chk("r_addr",       32'(r_addr),       32'(m_rcnt % DEPTH));
    endtask

    // One cycle: apply inputs just after an edge, check combinational
    // outputs, take the edge, update the model, then check registered state.
    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
        bit exp_push;
        bit exp_pop;
        wr     = w;
        rd     = r;
        w_data = d;
        clr    = c;
        #1;
        exp_push = w && ((q.size() < DEPTH) || r);
        exp_pop  = r && (q.size() != 0);
        if (!c) begin
            chk("wr_en", 32'(wr_en), 32'(exp_push));
            if (exp_pop) chk("r_data", 32'(r_data), 32'(q[0]));
        end
        @(posedge clk);
        if (c) begin
            model_clear();
        end else begin
            if (exp_pop) begin
                void'(q.pop_front());
                m_rcnt++;
            end
            if (exp_push) begin
                q.push_back(d);
                m_wcnt++;
            end
            if (w && !exp_push) m_ovf = 1'b1;
            if (r && !exp_pop)  m_unf = 1'b1;
        end
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        check_state();
    endtask

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_state();
        chk("idle_wr_en", 32'(wr_en), 32'(0));

        // Fill to depth
        step(1, 0, 8'hA1, 0);
        step(1, 0, 8'hB2, 0);
        step(1, 0, 8'hC3, 0);
        chk("af_at_3", 32'(almost_full), 32'(1));
        step(1, 0, 8'hD4, 0);
        chk("full_at_4", 32'(full), 32'(1));

        // Push while full: rejected, overflow set
        step(1, 0, 8'h99, 0);
        chk("ovf_set", 32'(overflow), 32'(1));

        // Drain, reading in order
        repeat (4) step(0, 1, 8'h00, 0);
        chk("r_addr_wrap", 32'(r_addr), 32'(0));

        // Full then simultaneous push/pop
        step(1, 0, 8'hA1, 0);
        step(1, 0, 8'hB2, 0);
        step(1, 0, 8'hC3, 0);
        step(1, 0, 8'hD4, 0);
        step(1, 1, 8'hEE, 0);
        chk("full_wr_rd_cnt", 32'(count), 32'(4));
        repeat (4) step(0, 1, 8'h00, 0);

        // Empty then simultaneous push/pop
        step(1, 1, 8'h55, 0);
        chk("empty_wr_rd_unf", 32'(underflow), 32'(1));
        step(0, 1, 8'h00, 0);

        // Partial fill with overflow pending, then clr (wr/rd also active)
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 1, 8'h33, 1);
        chk("clr_cnt", 32'(count), 32'(0));

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset between edges
        step(1, 0, 8'h77, 0);
        step(1, 0, 8'h88, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check_state();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 8'h42, 0);
        step(0, 1, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
